// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory-port and status signals around the memory-port arbiter.
// master: the arbiter (drives the memory port and the acks); slave: requesters plus memory.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [29:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [3:0]  ls_be;
    logic [29:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_ack;
    logic [31:0] ls_rdata;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        busy;

    modport master (
        input  if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata, mem_ack, mem_rdata,
        output if_ack, if_rdata, ls_ack, ls_rdata, err,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata, busy
    );

    modport slave (
        output if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata, mem_ack, mem_rdata,
        input  if_ack, if_rdata, ls_ack, ls_rdata, err,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one word-addressed memory port between instruction fetch (IF) and load/store (LS),
// with LS priority, an IF starvation guard and a timeout that turns a hung memory into err.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_WAIT     = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_port_arbiter_if.master   bus,
    output logic [1:0]           state_o
);
    // Handshake: a requester holds req (and its operands) high until its one-cycle ack;
    // the memory sees mem_req held with stable operands until mem_ack, which may come any later cycle.

    localparam int SW = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_RESP = 2'd2} state_t;

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic [7:0]      wait_q, wait_d;
    logic            err_pend_q, err_pend_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [3:0]      mem_be_q, mem_be_d;
    logic [29:0]     mem_addr_q, mem_addr_d;
    logic [31:0]     mem_wdata_q, mem_wdata_d;
    logic [31:0]     if_rdata_q, if_rdata_d;
    logic [31:0]     ls_rdata_q, ls_rdata_d;
    logic            grant_ls, grant_if;
    logic [31:0]     rdata_cap;

    // owner_q = 1 means LS owns the port; IF wins a tie only once LS has starved it.
    assign grant_ls  = bus.ls_req && (!bus.if_req || (starve_q != SW'(STARVE_LIMIT)));
    assign grant_if  = bus.if_req && !grant_ls;
    assign rdata_cap = mem_we_q ? 32'h0 : bus.mem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            starve_q    <= '0;
            wait_q      <= '0;
            err_pend_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            wait_q      <= wait_d;
            err_pend_q  <= err_pend_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        starve_d    = starve_q;
        wait_d      = wait_q;
        err_pend_d  = err_pend_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (grant_ls || grant_if) begin
                    state_d   = S_BUSY;
                    owner_d   = grant_ls;
                    wait_d    = 8'd1;
                    mem_req_d = 1'b1;
                    if (grant_ls) begin
                        mem_we_d    = bus.ls_we;
                        mem_be_d    = bus.ls_be;
                        mem_addr_d  = bus.ls_addr;
                        mem_wdata_d = bus.ls_wdata;
                        if (!bus.if_req)
                            starve_d = '0;
                        else if (starve_q != {SW{1'b1}})
                            starve_d = starve_q + 1'b1;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_be_d    = 4'hF;
                        mem_addr_d  = bus.if_addr;
                        mem_wdata_d = 32'h0;
                        starve_d    = '0;
                    end
                end
            end
            S_BUSY: begin
                // An ack on the last allowed cycle still wins over the timeout.
                if (bus.mem_ack) begin
                    state_d   = S_RESP;
                    mem_req_d = 1'b0;
                    if (owner_q) ls_rdata_d = rdata_cap;
                    else         if_rdata_d = rdata_cap;
                end else if (wait_q == 8'(MAX_WAIT)) begin
                    state_d    = S_RESP;
                    mem_req_d  = 1'b0;
                    err_pend_d = 1'b1;
                    if (owner_q) ls_rdata_d = 32'h0;
                    else         if_rdata_d = 32'h0;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_RESP: begin
                state_d    = S_IDLE;
                err_pend_d = 1'b0;
                wait_d     = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.if_ack = (state_q == S_RESP) && !owner_q;
        bus.ls_ack = (state_q == S_RESP) && owner_q;
        bus.err    = (state_q == S_RESP) && err_pend_q;
        bus.busy   = (state_q != S_IDLE);
        state_o    = state_q;
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table followed by hand-written
// sequences for starvation, timeout, late/stray acks and reset in the middle of a transaction.
module tb_mem_port_arbiter;
    localparam bit H = 1'b1;
    localparam bit L = 1'b0;

    logic        clk;
    logic        reset;
    logic [1:0]  state_o;
    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.STARVE_LIMIT(4), .MAX_WAIT(15)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .state_o (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ifr;
        logic [29:0] ifa;
        logic        lsr;
        logic        we;
        logic [3:0]  be;
        logic [29:0] lsa;
        logic [31:0] wd;
        logic        mack;
        logic [31:0] mrd;
        logic        e_mreq;
        logic        e_mwe;
        logic [3:0]  e_mbe;
        logic [29:0] e_maddr;
        logic [31:0] e_mwd;
        logic        e_ifack;
        logic        e_lsack;
        logic        e_err;
        logic        e_busy;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t        vecs[16];
    logic [31:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.ls_req    = 1'b0;
        bus.ls_we     = 1'b0;
        bus.ls_be     = '0;
        bus.ls_addr   = '0;
        bus.ls_wdata  = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
    endtask

    // LS keeps requesting while IF waits: expected winners are queued up front (1 = LS, 0 = IF).
    task automatic starve_seq(input string nm);
        logic [31:0] w;
        exp_q.delete();
        repeat (4) exp_q.push_back(32'd1);
        exp_q.push_back(32'd0);
        repeat (3) exp_q.push_back(32'd1);
        bus.if_req  = 1'b1;
        bus.if_addr = 30'h33;
        bus.ls_req  = 1'b1;
        bus.ls_we   = 1'b0;
        bus.ls_be   = 4'hF;
        bus.ls_addr = 30'h50;
        for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
            bus.mem_ack   = bus.mem_req;
            bus.mem_rdata = {2'b00, bus.mem_addr};
            @(posedge clk); #1;
            if (bus.if_ack || bus.ls_ack) begin
                w = exp_q.pop_front();
                chk({nm, " ack pair"}, {30'b0, bus.if_ack, bus.ls_ack}, (w != 0) ? 32'd1 : 32'd2);
                chk({nm, " err"}, 32'(bus.err), 32'd0);
                if (w != 0) chk({nm, " ls_rdata"}, bus.ls_rdata, 32'h50);
                else        chk({nm, " if_rdata"}, bus.if_rdata, 32'h33);
                if (w == 0) bus.if_req = 1'b0;
            end
        end
        chk({nm, " acks left"}, 32'(exp_q.size()), 32'd0);
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
    endtask

    // One LS load; memory acks on the lat-th cycle mem_req is seen high (lat = 0: never).
    task automatic ls_txn(input string nm, input logic [29:0] addr, input int lat,
                          input logic [31:0] rd, input logic exp_err, input int exp_req_cycles);
        int k;
        bit got;
        k   = 0;
        got = 1'b0;
        bus.if_req    = 1'b0;
        bus.ls_req    = 1'b1;
        bus.ls_we     = 1'b0;
        bus.ls_be     = 4'hF;
        bus.ls_addr   = addr;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = rd;
        for (int c = 0; c < 40 && !got; c++) begin
            @(posedge clk); #1;
            if (bus.ls_ack) begin
                got = 1'b1;
                chk({nm, " err"}, 32'(bus.err), 32'(exp_err));
                chk({nm, " ls_rdata"}, bus.ls_rdata, exp_err ? 32'h0 : rd);
                chk({nm, " mem_req cycles"}, 32'(k), 32'(exp_req_cycles));
                chk({nm, " mem_req at ack"}, 32'(bus.mem_req), 32'd0);
                chk({nm, " if_ack"}, 32'(bus.if_ack), 32'd0);
                bus.ls_req  = 1'b0;
                bus.mem_ack = 1'b0;
            end else begin
                if (bus.mem_req) begin
                    k++;
                    if (k == 1) chk({nm, " mem_addr"}, 32'(bus.mem_addr), 32'(addr));
                end
                bus.mem_ack = bus.mem_req && (k == lat);
            end
        end
        chk({nm, " ack seen"}, 32'(got), 32'd1);
    endtask

    initial begin
        int acks;
        int k;
        bit done;

        //            rst ifr ifa     lsr we be    lsa     wd            mack mrd            mreq mwe mbe   maddr   mwd           ifack lsack err busy rdata
        vecs[0]  = '{H, L, '0,     L, L, '0,   '0,     '0,           L, '0,             L, L, '0,   '0,     '0,           L, L, L, L, '0};
        vecs[1]  = '{L, H, 30'h10, L, L, '0,   '0,     '0,           L, '0,             H, L, 4'hF, 30'h10, '0,           L, L, L, H, '0};
        vecs[2]  = '{L, H, 30'h10, L, L, '0,   '0,     '0,           L, '0,             H, L, 4'hF, 30'h10, '0,           L, L, L, H, '0};
        vecs[3]  = '{L, H, 30'h10, L, L, '0,   '0,     '0,           H, 32'h00500093,   L, L, '0,   '0,     '0,           H, L, L, H, 32'h00500093};
        vecs[4]  = '{L, L, '0,     L, L, '0,   '0,     '0,           L, '0,             L, L, '0,   '0,     '0,           L, L, L, L, '0};
        vecs[5]  = '{L, L, '0,     H, H, 4'h3, 30'h7,  32'hDEADBEEF, L, '0,             H, H, 4'h3, 30'h7,  32'hDEADBEEF, L, L, L, H, '0};
        vecs[6]  = '{L, L, '0,     H, L, 4'hF, 30'h1,  '0,           L, '0,             H, H, 4'h3, 30'h7,  32'hDEADBEEF, L, L, L, H, '0};
        vecs[7]  = '{L, L, '0,     H, L, 4'hF, 30'h1,  '0,           H, 32'h12345678,   L, L, '0,   '0,     '0,           L, H, L, H, '0};
        vecs[8]  = '{L, L, '0,     L, L, '0,   '0,     '0,           L, '0,             L, L, '0,   '0,     '0,           L, L, L, L, '0};
        vecs[9]  = '{L, H, 30'h20, H, L, 4'hF, 30'h40, '0,           L, '0,             H, L, 4'hF, 30'h40, '0,           L, L, L, H, '0};
        vecs[10] = '{L, H, 30'h20, H, L, 4'hF, 30'h40, '0,           H, 32'hAAAA0001,   L, L, '0,   '0,     '0,           L, H, L, H, 32'hAAAA0001};
        vecs[11] = '{L, H, 30'h20, L, L, '0,   '0,     '0,           L, '0,             L, L, '0,   '0,     '0,           L, L, L, L, '0};
        vecs[12] = '{L, H, 30'h20, L, L, '0,   '0,     '0,           L, '0,             H, L, 4'hF, 30'h20, '0,           L, L, L, H, '0};
        vecs[13] = '{L, H, 30'h20, L, L, '0,   '0,     '0,           H, 32'hBBBB0002,   L, L, '0,   '0,     '0,           H, L, L, H, 32'hBBBB0002};
        vecs[14] = '{L, L, '0,     L, L, '0,   '0,     '0,           H, 32'hCCCC0003,   L, L, '0,   '0,     '0,           L, L, L, L, '0};
        vecs[15] = '{L, L, '0,     L, L, '0,   '0,     '0,           H, 32'hCCCC0004,   L, L, '0,   '0,     '0,           L, L, L, L, '0};

        reset = 1'b1;
        idle_inputs();
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            reset         = vecs[i].rst;
            bus.if_req    = vecs[i].ifr;
            bus.if_addr   = vecs[i].ifa;
            bus.ls_req    = vecs[i].lsr;
            bus.ls_we     = vecs[i].we;
            bus.ls_be     = vecs[i].be;
            bus.ls_addr   = vecs[i].lsa;
            bus.ls_wdata  = vecs[i].wd;
            bus.mem_ack   = vecs[i].mack;
            bus.mem_rdata = vecs[i].mrd;
            @(posedge clk); #1;
            chk($sformatf("v%0d mem_req", i), 32'(bus.mem_req), 32'(vecs[i].e_mreq));
            chk($sformatf("v%0d if_ack", i), 32'(bus.if_ack), 32'(vecs[i].e_ifack));
            chk($sformatf("v%0d ls_ack", i), 32'(bus.ls_ack), 32'(vecs[i].e_lsack));
            chk($sformatf("v%0d err", i), 32'(bus.err), 32'(vecs[i].e_err));
            chk($sformatf("v%0d busy", i), 32'(bus.busy), 32'(vecs[i].e_busy));
            if (vecs[i].e_mreq || vecs[i].rst) begin
                chk($sformatf("v%0d mem_we", i), 32'(bus.mem_we), 32'(vecs[i].e_mwe));
                chk($sformatf("v%0d mem_be", i), 32'(bus.mem_be), 32'(vecs[i].e_mbe));
                chk($sformatf("v%0d mem_addr", i), 32'(bus.mem_addr), 32'(vecs[i].e_maddr));
                chk($sformatf("v%0d mem_wdata", i), bus.mem_wdata, vecs[i].e_mwd);
            end
            if (vecs[i].e_ifack || vecs[i].rst)
                chk($sformatf("v%0d if_rdata", i), bus.if_rdata, vecs[i].e_rdata);
            if (vecs[i].e_lsack || vecs[i].rst)
                chk($sformatf("v%0d ls_rdata", i), bus.ls_rdata, vecs[i].e_rdata);
        end
        reset = 1'b0;
        idle_inputs();
        @(posedge clk); #1;

        starve_seq("starve");

        ls_txn("timeout", 30'h9, 0, 32'h0F0F0F0F, 1'b1, 15);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h77777777;
        repeat (2) begin
            @(posedge clk); #1;
            chk("late ack mem_req", 32'(bus.mem_req), 32'd0);
            chk("late ack acks", {30'b0, bus.if_ack, bus.ls_ack}, 32'd0);
            chk("late ack busy", 32'(bus.busy), 32'd0);
        end
        bus.mem_ack = 1'b0;
        ls_txn("after timeout", 30'hA, 1, 32'h11223344, 1'b0, 1);
        @(posedge clk); #1;
        ls_txn("ack at limit", 30'hB, 15, 32'h55667788, 1'b0, 15);
        @(posedge clk); #1;

        // Second LS grant of a contended pair is reset on its 3rd BUSY cycle.
        acks = 0;
        k    = 0;
        done = 1'b0;
        bus.if_req  = 1'b1;
        bus.if_addr = 30'h33;
        bus.ls_req  = 1'b1;
        bus.ls_we   = 1'b0;
        bus.ls_be   = 4'hF;
        bus.ls_addr = 30'h50;
        for (int c = 0; c < 40 && !done; c++) begin
            @(posedge clk); #1;
            if (bus.ls_ack) acks++;
            if (acks == 0) begin
                bus.mem_ack = bus.mem_req;
            end else begin
                bus.mem_ack = 1'b0;
                if (bus.mem_req) k++;
                if (k == 3) begin
                    reset = 1'b1;
                    done  = 1'b1;
                end
            end
        end
        chk("rst seq reached", 32'(done), 32'd1);
        chk("rst seq first ack", 32'(acks), 32'd1);
        @(posedge clk); #1;
        chk("rst mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst acks", {30'b0, bus.if_ack, bus.ls_ack}, 32'd0);
        reset = 1'b0;
        idle_inputs();
        @(posedge clk); #1;
        chk("post rst acks", {30'b0, bus.if_ack, bus.ls_ack}, 32'd0);
        chk("post rst mem_req", 32'(bus.mem_req), 32'd0);

        starve_seq("starve after reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
